// File: rtl/sprite_blitter.sv
// sprite_blitter: on start, walks a SPRITE_W x SPRITE_H pose ROM. It emits one registered x/y/colour/plot beat per pixel, with clipping and a colour key, and pulses done after the last beat.
module sprite_blitter #(
  parameter int         SPRITE_W    = 130,
  parameter int         SPRITE_H    = 120,
  parameter int         ADDR_W      = 14,
  parameter int         ROM_LATENCY = 1,
  parameter int         SCREEN_W    = 320,
  parameter int         SCREEN_H    = 240,
  parameter bit         TRANSP_EN   = 1'b1,
  parameter logic [2:0] TRANSP_KEY  = 3'b111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        sel,
  input  logic [8:0]        x0,
  input  logic [7:0]        y0,
  output logic              busy,
  output logic              done,
  output logic [1:0]        rom_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [2:0]        rom_q,
  output logic [8:0]        x,
  output logic [7:0]        y,
  output logic [2:0]        colour,
  output logic              plot
);
  localparam int L = ROM_LATENCY;
  localparam int N = SPRITE_W * SPRITE_H;
  localparam int CW = SPRITE_W > 1 ? $clog2(SPRITE_W) : 1;
  localparam int RW = SPRITE_H > 1 ? $clog2(SPRITE_H) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
  localparam logic [CW-1:0] COL_END = CW'(SPRITE_W - 1);
  localparam logic [9:0] SW = 10'(SCREEN_W);
  localparam logic [8:0] SH = 9'(SCREEN_H);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [8:0] x0_l;
  logic [7:0] y0_l;
  logic [L-1:0] pv;
  logic [CW-1:0] pcol [L];
  logic [RW-1:0] prow [L];
  logic [9:0] xs;
  logic [8:0] ys;
  logic last, wrap, vis;
  assign last = rom_addr == LAST;
  assign wrap = col == COL_END;
  assign xs = {1'b0, x0_l} + 10'(pcol[L-1]);
  assign ys = {1'b0, y0_l} + 9'(prow[L-1]);
  assign vis = pv[L-1] && xs < SW && ys < SH && !(TRANSP_EN && rom_q == TRANSP_KEY);
  assign busy = state == FETCH || state == DRAIN;
  assign done = state == DONE;
  always_comb
    nxt = state == IDLE  ? (start ? FETCH : IDLE) :
          state == FETCH ? (last ? DRAIN : FETCH) :
          state == DRAIN ? (|pv ? DRAIN : DONE) : IDLE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_sel <= '0;
      rom_addr <= '0;
      x0_l <= '0;
      y0_l <= '0;
      col <= '0;
      row <= '0;
      pv <= '0;
      pcol <= '{default: '0};
      prow <= '{default: '0};
      x <= '0;
      y <= '0;
      colour <= '0;
      plot <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        rom_sel <= sel;
        x0_l <= x0;
        y0_l <= y0;
        rom_addr <= '0;
        col <= '0;
        row <= '0;
      end else if (state == FETCH && !last) begin
        rom_addr <= rom_addr + 1'b1;
        col <= wrap ? '0 : col + 1'b1;
        row <= wrap ? row + 1'b1 : row;
      end
      pv <= L'({pv, state == FETCH});
      pcol[0] <= col;
      prow[0] <= row;
      for (int k = 1; k < L; k++) begin
        pcol[k] <= pcol[k-1];
        prow[k] <= prow[k-1];
      end
      if (pv[L-1]) begin
        x <= xs[8:0];
        y <= ys[7:0];
        colour <= rom_q;
      end
      plot <= vis;
    end
  end
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: randomized checks of sprite_blitter against a pixel-order reference model
module tb_sprite_blitter;
  localparam int CAPN = 15700;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [1:0] sel = '0;
  logic [8:0] x0 = '0;
  logic [7:0] y0 = '0;
  logic busy_a, done_a, plot_a, busy_b, done_b, plot_b, busy_c, done_c, plot_c;
  logic [1:0] rom_sel_a, rom_sel_b, rom_sel_c;
  logic [3:0] rom_addr_a, rom_addr_b;
  logic [13:0] rom_addr_c;
  logic [2:0] q_a, q_b, qb1, q_c, colour_a, colour_b, colour_c;
  logic [8:0] x_a, x_b, x_c;
  logic [7:0] y_a, y_b, y_c;
  logic [2:0] rom_mem [16];
  int checks = 0;
  int errors = 0;
  bit cp_plot [CAPN], cp_done [CAPN], cp_busy [CAPN];
  int cp_x [CAPN], cp_y [CAPN], cp_col [CAPN], cp_addr [CAPN], cp_sel [CAPN];
  bit ex_v [CAPN], ex_plot [CAPN], ex_done [CAPN], ex_busy [CAPN];
  int ex_x [CAPN], ex_y [CAPN], ex_col [CAPN];

  always #5 clk = ~clk;

  always @(posedge clk) q_a <= rom_mem[rom_addr_a];
  always @(posedge clk) begin
    qb1 <= rom_mem[rom_addr_b];
    q_b <= qb1;
  end
  always @(posedge clk) q_c <= 3'(rom_addr_c % 14'd7);

  sprite_blitter #(.SPRITE_W(4), .SPRITE_H(3), .ADDR_W(4), .ROM_LATENCY(1)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .sel(sel), .x0(x0), .y0(y0),
    .busy(busy_a), .done(done_a), .rom_sel(rom_sel_a), .rom_addr(rom_addr_a), .rom_q(q_a),
    .x(x_a), .y(y_a), .colour(colour_a), .plot(plot_a));

  sprite_blitter #(.SPRITE_W(4), .SPRITE_H(3), .ADDR_W(4), .ROM_LATENCY(2)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .sel(sel), .x0(x0), .y0(y0),
    .busy(busy_b), .done(done_b), .rom_sel(rom_sel_b), .rom_addr(rom_addr_b), .rom_q(q_b),
    .x(x_b), .y(y_b), .colour(colour_b), .plot(plot_b));

  sprite_blitter u_c (
    .clk(clk), .reset(reset), .start(start_c), .sel(sel), .x0(x0), .y0(y0),
    .busy(busy_c), .done(done_c), .rom_sel(rom_sel_c), .rom_addr(rom_addr_c), .rom_q(q_c),
    .x(x_c), .y(y_c), .colour(colour_c), .plot(plot_c));

  // Expected beats per cycle, cycle 0 being the cycle start is sampled.
  task automatic build_model(input int w, input int h, input int lat, input int xo, input int yo, input bit big);
    int np;
    np = w * h;
    for (int c = 0; c < CAPN; c++) begin
      ex_v[c] = 0;
      ex_plot[c] = 0;
      ex_done[c] = c == np + 2 + lat;
      ex_busy[c] = c >= 1 && c <= np + 1 + lat;
    end
    for (int n = 0; n < np; n++) begin
      int c, px, py, q;
      c = n + 2 + lat;
      px = xo + n % w;
      py = yo + n / w;
      q = big ? n % 7 : int'(rom_mem[n % 16]);
      ex_v[c] = 1;
      ex_x[c] = px % 512;
      ex_y[c] = py % 256;
      ex_col[c] = q;
      ex_plot[c] = px < 320 && py < 240 && q != 7;
    end
  endtask

  // Starts the chosen DUT and records its outputs at each negedge.
  task automatic capture(input int dut, input int ncyc, input logic [31:0] smask, input int rst_at);
    @(posedge clk);
    #1;
    start_a = dut == 0;
    start_b = dut == 1;
    start_c = dut == 2;
    for (int c = 0; c < ncyc; c++) begin
      bit st;
      @(negedge clk);
      if (rst_at >= 0 && c == rst_at) begin
        reset = 0;
        #1;
      end
      if (rst_at >= 0 && c == rst_at + 3) reset = 1;
      cp_plot[c] = dut == 0 ? plot_a : dut == 1 ? plot_b : plot_c;
      cp_done[c] = dut == 0 ? done_a : dut == 1 ? done_b : done_c;
      cp_busy[c] = dut == 0 ? busy_a : dut == 1 ? busy_b : busy_c;
      cp_x[c] = dut == 0 ? int'(x_a) : dut == 1 ? int'(x_b) : int'(x_c);
      cp_y[c] = dut == 0 ? int'(y_a) : dut == 1 ? int'(y_b) : int'(y_c);
      cp_col[c] = dut == 0 ? int'(colour_a) : dut == 1 ? int'(colour_b) : int'(colour_c);
      cp_addr[c] = dut == 0 ? int'(rom_addr_a) : dut == 1 ? int'(rom_addr_b) : int'(rom_addr_c);
      cp_sel[c] = dut == 0 ? int'(rom_sel_a) : dut == 1 ? int'(rom_sel_b) : int'(rom_sel_c);
      st = c < 32 && smask[c % 32];
      if (st && c > 0) begin
        sel = 2'($urandom);
        x0 = 9'($urandom_range(0, 319));
        y0 = 8'($urandom_range(0, 239));
      end
      start_a = dut == 0 && st;
      start_b = dut == 1 && st;
      start_c = dut == 2 && st;
    end
    start_a = 0;
    start_b = 0;
    start_c = 0;
  endtask

  task automatic test_reset;
    reset = 0;
    start_a = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy_a, done_a, plot_a, rom_sel_a, rom_addr_a, x_a, y_a, colour_a} !== '0) begin
      errors++;
      $display("FAIL reset_a got %h exp 0", {busy_a, done_a, plot_a, rom_sel_a, rom_addr_a, x_a, y_a, colour_a});
    end
    checks++;
    if ({busy_b, done_b, plot_b, rom_sel_b, rom_addr_b, x_b, y_b, colour_b} !== '0) begin
      errors++;
      $display("FAIL reset_b got %h exp 0", {busy_b, done_b, plot_b, rom_sel_b, rom_addr_b, x_b, y_b, colour_b});
    end
    checks++;
    if ({busy_c, done_c, plot_c, rom_sel_c, rom_addr_c, x_c, y_c, colour_c} !== '0) begin
      errors++;
      $display("FAIL reset_c got %h exp 0", {busy_c, done_c, plot_c, rom_sel_c, rom_addr_c, x_c, y_c, colour_c});
    end
    start_a = 0;
    reset = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy got %b exp 0", busy_a);
    end
  endtask

  task automatic test_raster;
    for (int t = 0; t < 5; t++) begin
      int xo, yo, np;
      xo = t == 0 ? 90 : t == 1 ? 318 : $urandom_range(0, 319);
      yo = t == 0 ? 70 : t == 1 ? 238 : $urandom_range(0, 239);
      foreach (rom_mem[i]) rom_mem[i] = t == 0 ? 3'(i) : t == 1 ? 3'($urandom_range(0, 6)) : 3'($urandom);
      if (t != 1) rom_mem[5] = 3'b111;
      sel = 2'($urandom);
      x0 = 9'(xo);
      y0 = 8'(yo);
      build_model(4, 3, 1, xo, yo, 0);
      capture(0, 18, 32'h1, -1);
      np = 0;
      for (int c = 0; c < 18; c++) begin
        np += int'(cp_plot[c]);
        checks++;
        if (cp_plot[c] !== ex_plot[c]) begin errors++; $display("FAIL raster t%0d plot c%0d got %0d exp %0d", t, c, cp_plot[c], ex_plot[c]); end
        checks++;
        if (cp_done[c] !== ex_done[c]) begin errors++; $display("FAIL raster t%0d done c%0d got %0d exp %0d", t, c, cp_done[c], ex_done[c]); end
        checks++;
        if (cp_busy[c] !== ex_busy[c]) begin errors++; $display("FAIL raster t%0d busy c%0d got %0d exp %0d", t, c, cp_busy[c], ex_busy[c]); end
        if (ex_v[c]) begin
          checks++;
          if (cp_x[c] != ex_x[c] || cp_y[c] != ex_y[c] || cp_col[c] != ex_col[c]) begin
            errors++;
            $display("FAIL raster t%0d pixel c%0d got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", t, c, cp_x[c], cp_y[c], cp_col[c], ex_x[c], ex_y[c], ex_col[c]);
          end
        end
      end
      for (int c = 1; c <= 12; c++) begin
        checks++;
        if (cp_addr[c] != c - 1) begin errors++; $display("FAIL raster t%0d rom_addr c%0d got %0d exp %0d", t, c, cp_addr[c], c - 1); end
      end
      if (t == 1) begin
        checks++;
        if (np != 4) begin errors++; $display("FAIL clip_count got %0d exp 4", np); end
      end
    end
  endtask

  task automatic test_latency2;
    for (int t = 0; t < 3; t++) begin
      int xo, yo;
      xo = $urandom_range(0, 319);
      yo = $urandom_range(0, 239);
      foreach (rom_mem[i]) rom_mem[i] = 3'($urandom);
      sel = 2'($urandom);
      x0 = 9'(xo);
      y0 = 8'(yo);
      build_model(4, 3, 2, xo, yo, 0);
      capture(1, 19, 32'h1, -1);
      for (int c = 0; c < 19; c++) begin
        checks++;
        if (cp_plot[c] !== ex_plot[c]) begin errors++; $display("FAIL lat2 t%0d plot c%0d got %0d exp %0d", t, c, cp_plot[c], ex_plot[c]); end
        checks++;
        if (cp_done[c] !== ex_done[c]) begin errors++; $display("FAIL lat2 t%0d done c%0d got %0d exp %0d", t, c, cp_done[c], ex_done[c]); end
        checks++;
        if (cp_busy[c] !== ex_busy[c]) begin errors++; $display("FAIL lat2 t%0d busy c%0d got %0d exp %0d", t, c, cp_busy[c], ex_busy[c]); end
        if (ex_v[c]) begin
          checks++;
          if (cp_x[c] != ex_x[c] || cp_y[c] != ex_y[c] || cp_col[c] != ex_col[c]) begin
            errors++;
            $display("FAIL lat2 t%0d pixel c%0d got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", t, c, cp_x[c], cp_y[c], cp_col[c], ex_x[c], ex_y[c], ex_col[c]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int xo, yo, s0;
    foreach (rom_mem[i]) rom_mem[i] = 3'($urandom);
    xo = $urandom_range(0, 319);
    yo = $urandom_range(0, 239);
    s0 = $urandom_range(1, 3);
    sel = 2'(s0);
    x0 = 9'(xo);
    y0 = 8'(yo);
    build_model(4, 3, 1, xo, yo, 0);
    capture(0, 34, 32'h18021, -1);
    for (int c = 0; c < 16; c++) begin
      checks++;
      if (cp_plot[c] !== ex_plot[c] || cp_done[c] !== ex_done[c] || cp_busy[c] !== ex_busy[c]) begin
        errors++;
        $display("FAIL b2b first ctrl c%0d got p%0d d%0d b%0d exp p%0d d%0d b%0d", c, cp_plot[c], cp_done[c], cp_busy[c], ex_plot[c], ex_done[c], ex_busy[c]);
      end
      if (ex_v[c]) begin
        checks++;
        if (cp_x[c] != ex_x[c] || cp_y[c] != ex_y[c] || cp_col[c] != ex_col[c]) begin
          errors++;
          $display("FAIL b2b first pixel c%0d got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", c, cp_x[c], cp_y[c], cp_col[c], ex_x[c], ex_y[c], ex_col[c]);
        end
      end
    end
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if (cp_sel[c] != s0) begin errors++; $display("FAIL b2b rom_sel c%0d got %0d exp %0d", c, cp_sel[c], s0); end
    end
    build_model(4, 3, 1, int'(x0), int'(y0), 0);
    for (int c = 0; c < 18; c++) begin
      checks++;
      if (cp_plot[c+16] !== ex_plot[c] || cp_done[c+16] !== ex_done[c] || cp_busy[c+16] !== ex_busy[c]) begin
        errors++;
        $display("FAIL b2b second ctrl c%0d got p%0d d%0d b%0d exp p%0d d%0d b%0d", c + 16, cp_plot[c+16], cp_done[c+16], cp_busy[c+16], ex_plot[c], ex_done[c], ex_busy[c]);
      end
      if (ex_v[c]) begin
        checks++;
        if (cp_x[c+16] != ex_x[c] || cp_y[c+16] != ex_y[c] || cp_col[c+16] != ex_col[c]) begin
          errors++;
          $display("FAIL b2b second pixel c%0d got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", c + 16, cp_x[c+16], cp_y[c+16], cp_col[c+16], ex_x[c], ex_y[c], ex_col[c]);
        end
      end
    end
    checks++;
    if (cp_sel[17] != int'(sel)) begin errors++; $display("FAIL b2b rom_sel_new got %0d exp %0d", cp_sel[17], sel); end
  endtask

  task automatic test_reset_mid_draw;
    int xo, yo, s0, act;
    foreach (rom_mem[i]) rom_mem[i] = 3'($urandom_range(1, 6));
    xo = $urandom_range(1, 200);
    yo = $urandom_range(1, 200);
    s0 = $urandom_range(1, 3);
    sel = 2'(s0);
    x0 = 9'(xo);
    y0 = 8'(yo);
    build_model(4, 3, 1, xo, yo, 0);
    capture(0, 26, 32'h1, 7);
    for (int c = 0; c < 7; c++) begin
      checks++;
      if (cp_plot[c] !== ex_plot[c]) begin errors++; $display("FAIL midreset pre plot c%0d got %0d exp %0d", c, cp_plot[c], ex_plot[c]); end
    end
    checks++;
    if (cp_busy[7] || cp_plot[7] || cp_done[7] || cp_x[7] != 0 || cp_y[7] != 0 || cp_col[7] != 0 || cp_addr[7] != 0 || cp_sel[7] != 0) begin
      errors++;
      $display("FAIL midreset zero got b%0d p%0d x%0d y%0d c%0d a%0d s%0d exp all 0", cp_busy[7], cp_plot[7], cp_x[7], cp_y[7], cp_col[7], cp_addr[7], cp_sel[7]);
    end
    act = 0;
    for (int c = 7; c < 26; c++) act += int'(cp_done[c]) + int'(cp_plot[c]) + int'(cp_busy[c]);
    checks++;
    if (act != 0) begin errors++; $display("FAIL midreset activity got %0d exp 0", act); end
    capture(0, 18, 32'h1, -1);
    for (int c = 0; c < 18; c++) begin
      checks++;
      if (cp_plot[c] !== ex_plot[c] || cp_done[c] !== ex_done[c]) begin
        errors++;
        $display("FAIL midreset redraw c%0d got p%0d d%0d exp p%0d d%0d", c, cp_plot[c], cp_done[c], ex_plot[c], ex_done[c]);
      end
      if (ex_v[c]) begin
        checks++;
        if (cp_x[c] != ex_x[c] || cp_y[c] != ex_y[c] || cp_col[c] != ex_col[c]) begin
          errors++;
          $display("FAIL midreset redraw pixel c%0d got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", c, cp_x[c], cp_y[c], cp_col[c], ex_x[c], ex_y[c], ex_col[c]);
        end
      end
    end
  endtask

  task automatic test_default;
    int nplot, ndone, dcyc, lx, ly, bad;
    nplot = 0;
    ndone = 0;
    dcyc = -1;
    lx = -1;
    ly = -1;
    bad = 0;
    sel = 2'd1;
    x0 = 9'd90;
    y0 = 8'd70;
    build_model(130, 120, 1, 90, 70, 1);
    capture(2, 15606, 32'h1, -1);
    for (int c = 0; c < 15606; c++) begin
      if (cp_plot[c]) begin
        nplot++;
        lx = cp_x[c];
        ly = cp_y[c];
      end
      if (cp_done[c]) begin
        ndone++;
        dcyc = c;
      end
      if (cp_plot[c] !== ex_plot[c] || cp_busy[c] !== ex_busy[c] || (ex_v[c] && (cp_x[c] != ex_x[c] || cp_y[c] != ex_y[c] || cp_col[c] != ex_col[c]))) bad++;
    end
    checks++;
    if (nplot != 15600) begin errors++; $display("FAIL default plots got %0d exp 15600", nplot); end
    checks++;
    if (ndone != 1 || dcyc != 15603) begin errors++; $display("FAIL default done got %0d pulses at %0d exp 1 at 15603", ndone, dcyc); end
    checks++;
    if (lx != 219 || ly != 189) begin errors++; $display("FAIL default last got (%0d,%0d) exp (219,189)", lx, ly); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL default beats got %0d bad cycles exp 0", bad); end
    checks++;
    if (cp_sel[1] != 1) begin errors++; $display("FAIL default rom_sel got %0d exp 1", cp_sel[1]); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_raster();
    test_latency2();
    test_back_to_back();
    test_reset_mid_draw();
    test_default();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
Drawing engine between the animation control FSM and vga_adapter. On a start pulse it walks a W x H sprite held in one of up to four pose ROMs, centre, right, left or spare, selected by a mux outside this block. It compensates for the ROM read latency and emits one registered x/y/colour/plot beat per pixel at an arbitrary screen origin, with colour-key transparency and screen clipping. It replaces the free-running Xout/Yout/Drawcount walker and reports completion with a single done pulse.

Parameters:
SPRITE_W, 130, sprite width in pixels
SPRITE_H, 120, sprite height in pixels
ADDR_W, 14, ROM address width; must satisfy SPRITE_W*SPRITE_H <= 2^ADDR_W
ROM_LATENCY, 1, cycles from rom_addr to valid rom_q; legal values 1 or 2
SCREEN_W, 320, visible columns
SCREEN_H, 240, visible rows
TRANSP_EN, 1, enables colour-key suppression
TRANSP_KEY, 3'b111, colour treated as transparent

Ports:
clk  in  1  system clock (CLOCK_50)
reset  in  1  asynchronous active-low reset
start  in  1  request a draw; sampled only in IDLE
sel  in  2  pose select, latched at start
x0  in  9  sprite origin column, latched at start
y0  in  8  sprite origin row, latched at start
busy  out  1  high from the cycle after start is accepted through the done cycle exclusive
done  out  1  one-cycle pulse when the last pixel has been emitted
rom_sel  out  2  latched sel; drives the external ROM mux
rom_addr  out  ADDR_W  ROM read address
rom_q  in  3  colour from the selected ROM
x  out  9  pixel column to vga_adapter
y  out  8  pixel row to vga_adapter
colour  out  3  pixel colour to vga_adapter
plot  out  1  write strobe to vga_adapter

Behaviour:
- Async reset (reset=0) applies immediately, regardless of state:
  - state <- IDLE; pipeline valids cleared.
  - busy, done, plot, x, y, colour, rom_addr, rom_sel all 0.
  - A reset mid-draw abandons the sprite; no done pulse is produced.
- States IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - On start=1 at edge E0: latch sel/x0/y0; col=row=0; rom_addr<=0; go to FETCH.
  - Cycle 0 is the cycle in which start is sampled.
- FETCH:
  - Address n = row*SPRITE_W+col is presented in cycle n+1, from a running counter with no multiplier.
  - col increments each cycle; at col=SPRITE_W-1 it wraps to 0 and row increments.
  - A (col,row,valid) tag enters a ROM_LATENCY-deep shift pipeline alongside each address.
  - After issuing N-1, where N=SPRITE_W*SPRITE_H, go to DRAIN. rom_addr then holds N-1.
- DRAIN: wait until the pipeline is empty, then go to DONE.
- Output stage, registered:
  - rom_q for address n is valid in cycle n+1+ROM_LATENCY.
  - x<=x0+col and y<=y0+row are visible in cycle n+2+ROM_LATENCY, together with colour<=rom_q and plot.
  - plot=1 only if all three hold: the tag is valid; x0+col<SCREEN_W and y0+row<SCREEN_H, computed one bit wider to catch overflow; and !(TRANSP_EN && rom_q==TRANSP_KEY).
  - x, y and colour update even when plot=0.
  - plot=0 outside valid beats.
- DONE:
  - done=1 for exactly one cycle, N+2+ROM_LATENCY; busy=0 in that cycle.
  - Return to IDLE.
  - A start in the DONE cycle is ignored. A start on the following cycle is accepted.
- start while busy or in DONE is ignored; the latched sel/x0/y0 are unaffected.
- rom_sel is constant for the whole draw. It holds its value after done until the next accepted start.
- Total draw time is N+2+ROM_LATENCY cycles from start to done. Throughput is one pixel per clock with no bubbles.

Test Plan:
- Basic raster (W=4,H=3,L=1,TRANSP_EN=0; ROM model q=addr[2:0]; x0=90,y0=70, start at cycle 0):
  - rom_addr 0..11 in cycles 1..12.
  - plot in cycles 3..14, with (x,y) = (90,70),(91,70),(92,70),(93,70),(90,71)...(93,72); colour=addr[2:0].
  - done=1 in cycle 15 only; busy high cycles 1..14.
- Latency 2 (same setup, L=2): plots in cycles 4..15; done in cycle 16; pixel order unchanged.
- Transparency and clipping:
  - ROM returns 3'b111 at address 5: plot=0 for that beat, with x,y still advancing.
  - x0=318,y0=238: only (318,238),(319,238),(318,239),(319,239) plotted; 4 beats total.
- Busy handling: start pulsed again at cycle 5 with sel=2, x0=0 -> ignored; rom_sel and x sequence unchanged. Start in the DONE cycle is ignored; start at cycle 16 is accepted and redraws.
- Reset mid-draw: reset low at cycle 7 (async, between edges):
  - All outputs go to 0 immediately.
  - No done pulse follows.
  - After release, a new start produces the full 12-beat sequence from address 0.
- Default params (130x120, L=1), sel=1, x0=90,y0=70: 15600 plots, last at (219,189), done at cycle 15603.
